// File: rtl/ram_proj_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_proj_pkg
//  Description : Shared constants and types for the ram_proj SRAM model.
//                DATA_WIDTH  - word width in bits (multiple of 8)
//                ADDR_WIDTH  - word address width
//                NUM_WMASKS  - one write-enable bit per byte
//                DEPTH       - number of words
//  Revision    : 1.0  initial release
// ============================================================================
package ram_proj_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 8;
    localparam int NUM_WMASKS = DATA_WIDTH / 8;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [NUM_WMASKS-1:0] wmask_t;

endpackage : ram_proj_pkg
`default_nettype wire

// File: rtl/ram_proj_wmask_merge.sv
`default_nettype none
// ============================================================================
//  Module      : ram_proj_wmask_merge
//  Description : Combinational byte merge for masked writes. Each byte of the
//                result comes from the new word when its mask bit is set,
//                otherwise from the old word.
//  Ports       : i_old   - current memory word
//                i_new   - incoming write data
//                i_mask  - byte enables, bit i covers byte i
//                o_word  - merged word to store
//  Revision    : 1.0  initial release
// ============================================================================
module ram_proj_wmask_merge
    import ram_proj_pkg::*;
#(
    parameter int DW = ram_proj_pkg::DATA_WIDTH,
    parameter int NM = ram_proj_pkg::NUM_WMASKS
) (
    input  logic [DW-1:0] i_old,
    input  logic [DW-1:0] i_new,
    input  logic [NM-1:0] i_mask,
    output logic [DW-1:0] o_word
);

    for (genvar gi = 0; gi < NM; gi++) begin : g_byte
        assign o_word[8*gi +: 8] = i_mask[gi] ? i_new[8*gi +: 8]
                                              : i_old[8*gi +: 8];
    end

endmodule : ram_proj_wmask_merge
`default_nettype wire

// File: rtl/ram_proj.sv
`default_nettype none
// ============================================================================
//  Module      : ram_proj
//  Description : Single-clock two-port synchronous SRAM model.
//                Port 0 is read/write with per-byte write mask, port 1 is
//                read-only. Both read ports are registered (1-cycle latency).
//                Same-address port-0 write / port-1 read is read-before-write.
//                Reset clears only the output registers; storage is retained.
//  Ports       : clk0    - sole clock, rising edge
//                rst_n   - asynchronous active-low reset
//                cs0/we0/wmask0/addr0/din0 - port-0 controls and write data
//                dout0   - port-0 registered read data
//                cs1/addr1 - port-1 controls
//                dout1   - port-1 registered read data
//  Revision    : 1.0  initial release
// ============================================================================
module ram_proj
    import ram_proj_pkg::*;
#(
    parameter int DATA_WIDTH = ram_proj_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = ram_proj_pkg::ADDR_WIDTH,
    parameter int NUM_WMASKS = DATA_WIDTH / 8
) (
    input  logic                  clk0,
    input  logic                  rst_n,
    input  logic                  cs0,
    input  logic                  we0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    input  logic                  cs1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1
);

    localparam int C_DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [C_DEPTH];
    logic [DATA_WIDTH-1:0] r_dout0;
    logic [DATA_WIDTH-1:0] r_dout1;
    logic [DATA_WIDTH-1:0] w_merged;
    logic                  w_wr0;
    logic                  w_rd0;

    assign w_wr0 = cs0 &  we0;
    assign w_rd0 = cs0 & ~we0;

    ram_proj_wmask_merge #(
        .DW (DATA_WIDTH),
        .NM (NUM_WMASKS)
    ) u_merge (
        .i_old  (r_mem[addr0]),
        .i_new  (din0),
        .i_mask (wmask0),
        .o_word (w_merged)
    );

    // Storage shares the reset-gated branch so that no access happens while
    // rst_n is low, but the array itself is never cleared. Non-blocking reads
    // of r_mem give port 1 the pre-write word on an address collision.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_dout0 <= '0;
            r_dout1 <= '0;
        end else begin
            if (w_wr0) begin
                r_mem[addr0] <= w_merged;
            end
            if (w_rd0) begin
                r_dout0 <= r_mem[addr0];
            end
            if (cs1) begin
                r_dout1 <= r_mem[addr1];
            end
        end
    end

    assign dout0 = r_dout0;
    assign dout1 = r_dout1;

endmodule : ram_proj
`default_nettype wire

// File: tb/tb_ram_proj.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_proj
//  Description : Directed self-checking bench for ram_proj. Port signals are
//                grouped in port0_intf / port1_intf bundles.
//  Revision    : 1.0  initial release
// ============================================================================
interface port0_intf;
    logic        cs;
    logic        we;
    logic [3:0]  wmask;
    logic [7:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
endinterface

interface port1_intf;
    logic        cs;
    logic [7:0]  addr;
    logic [31:0] dout;
endinterface

module tb_ram_proj;

    logic clk0;
    logic rst_n;
    int   vectors;
    int   errors;

    port0_intf p0();
    port1_intf p1();

    ram_proj dut (
        .clk0   (clk0),
        .rst_n  (rst_n),
        .cs0    (p0.cs),
        .we0    (p0.we),
        .wmask0 (p0.wmask),
        .addr0  (p0.addr),
        .din0   (p0.din),
        .dout0  (p0.dout),
        .cs1    (p1.cs),
        .addr1  (p1.addr),
        .dout1  (p1.dout)
    );

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one rising edge, then settle away from it
    task automatic tick();
        @(posedge clk0);
        #1;
    endtask

    task automatic p0_set(input logic cs, input logic we, input logic [3:0] m,
                          input logic [7:0] a, input logic [31:0] d);
        p0.cs = cs; p0.we = we; p0.wmask = m; p0.addr = a; p0.din = d;
    endtask

    task automatic p1_set(input logic cs, input logic [7:0] a);
        p1.cs = cs; p1.addr = a;
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst_n   = 1'b0;
        p0_set(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
        p1_set(1'b0, 8'h00);

        tick();
        check("reset_dout0", p0.dout, 32'h0);
        check("reset_dout1", p1.dout, 32'h0);
        #2 rst_n = 1'b1;
        tick();

        // seed locations
        p0_set(1'b1, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF); tick();
        p0_set(1'b1, 1'b1, 4'hF, 8'h3F, 32'hA5A5A5A5); tick();
        check("write_holds_dout0", p0.dout, 32'h0);

        // full write, cross-port read (wmask ignored on read)
        p0_set(1'b1, 1'b0, 4'h0, 8'h3F, 32'h0);
        p1_set(1'b1, 8'h3F); tick();
        check("full_wr_dout0", p0.dout, 32'hA5A5A5A5);
        check("full_wr_dout1", p1.dout, 32'hA5A5A5A5);

        // byte mask 0101
        p1_set(1'b0, 8'h00);
        p0_set(1'b1, 1'b1, 4'b0101, 8'h3F, 32'h11223344); tick();
        check("mask_wr_holds_dout0", p0.dout, 32'hA5A5A5A5);
        p0_set(1'b1, 1'b0, 4'hF, 8'h3F, 32'h0); tick();
        check("mask_readback", p0.dout, 32'hA522A544);
        check("cs1_off_dout1", p1.dout, 32'hA5A5A5A5);

        // zero-mask write is a no-op
        p0_set(1'b1, 1'b1, 4'h0, 8'h3F, 32'hFFFFFFFF); tick();
        p0_set(1'b1, 1'b0, 4'h0, 8'h3F, 32'h0); tick();
        check("zero_mask_noop", p0.dout, 32'hA522A544);

        // collision: read-before-write on port 1
        p0_set(1'b1, 1'b1, 4'hF, 8'h80, 32'h00000000); tick();
        p0_set(1'b1, 1'b1, 4'hF, 8'h80, 32'hCAFEF00D);
        p1_set(1'b1, 8'h80); tick();
        check("collision_old", p1.dout, 32'h00000000);
        p0_set(1'b0, 1'b0, 4'h0, 8'h00, 32'h0); tick();
        check("collision_new", p1.dout, 32'hCAFEF00D);

        // chip-select hold on port 1
        p1_set(1'b0, 8'h3F);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("cs1_hold", p1.dout, 32'hCAFEF00D);
        end

        // cs0=0 blocks the write
        p0_set(1'b0, 1'b1, 4'hF, 8'h3F, 32'h0); tick();
        p0_set(1'b1, 1'b0, 4'hF, 8'h3F, 32'h0); tick();
        check("cs0_off_no_write", p0.dout, 32'hA522A544);

        // address boundaries
        p0_set(1'b1, 1'b1, 4'hF, 8'h00, 32'hFFFFFFFF); tick();
        check("bnd_wr0_holds", p0.dout, 32'hA522A544);
        p0_set(1'b1, 1'b1, 4'hF, 8'hFF, 32'h12345678); tick();
        check("bnd_wrff_holds", p0.dout, 32'hA522A544);
        p0_set(1'b1, 1'b0, 4'h0, 8'h00, 32'h0);
        p1_set(1'b1, 8'hFF); tick();
        check("bnd_rd00_p0", p0.dout, 32'hFFFFFFFF);
        check("bnd_rdff_p1", p1.dout, 32'h12345678);
        p0_set(1'b1, 1'b0, 4'h0, 8'hFF, 32'h0);
        p1_set(1'b1, 8'h00); tick();
        check("bnd_rdff_p0", p0.dout, 32'h12345678);
        check("bnd_rd00_p1", p1.dout, 32'hFFFFFFFF);

        // both ports read the same word
        p0_set(1'b1, 1'b0, 4'h0, 8'h10, 32'h0);
        p1_set(1'b1, 8'h10); tick();
        check("same_addr_p0", p0.dout, 32'hDEADBEEF);
        check("same_addr_p1", p1.dout, 32'hDEADBEEF);

        // asynchronous reset mid-cycle, with a write attempted during reset
        p0_set(1'b1, 1'b1, 4'hF, 8'h10, 32'h00000000);
        p1_set(1'b1, 8'h3F);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_dout0", p0.dout, 32'h0);
        check("async_rst_dout1", p1.dout, 32'h0);
        tick();
        check("in_rst_dout0", p0.dout, 32'h0);
        check("in_rst_dout1", p1.dout, 32'h0);
        p0_set(1'b1, 1'b0, 4'h0, 8'h10, 32'h0);
        p1_set(1'b1, 8'h10);
        #2 rst_n = 1'b1;
        tick();
        check("retained_p0", p0.dout, 32'hDEADBEEF);
        check("retained_p1", p1.dout, 32'hDEADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // absolute time bound
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule : tb_ram_proj
`default_nettype wire
